basic_skid_slice: RTL and testbench
===================================

// Module: basic_skid_slice
// PURPOSE
//  Two-entry valid/ready register slice (skid buffer) cutting all combinational paths between an
//  upstream producer and a downstream consumer. Inserted on long datapaths between pipeline
//  stages; full throughput (1 beat/cycle), 1-cycle latency, both s_ready and m_valid registered.
// PARAMETERS
//  DW      32   payload width in bits
// PORTS
//  CLK       in   1    clock, all state updates on rising edge
//  RSTn      in   1    reset, asynchronous, active-low
//  s_valid   in   1    upstream beat valid
//  s_ready   out  1    slice can accept a beat (registered)
//  s_data    in   DW   upstream payload
//  m_valid   out  1    downstream beat valid (registered)
//  m_ready   in   1    downstream accepts beat
//  m_data    out  DW   downstream payload (registered, main entry)
//  stall_cnt out  16   only with SKID_STALL_CNT_EN, see CONFIGURATION
// BEHAVIOUR
//  - push = s_valid & s_ready; pop = m_valid & m_ready; both sampled at rising CLK.
//  - Storage: main reg (drives m_data), skid reg (holds overflow beat).
//  - States: EMPTY (none valid), ONE (main valid), FULL (main+skid valid). m_valid = state!=EMPTY.
//  - EMPTY: push -> ONE, main<=s_data. No push -> stay.
//  - ONE: push&!pop -> FULL, skid<=s_data. pop&!push -> EMPTY. push&pop -> ONE, main<=s_data.
//    neither -> stay.
//  - FULL: s_ready=0 so no push; pop -> ONE, main<=skid. No pop -> stay, main/skid frozen.
//  - s_ready is a flop: s_ready <= (next_state != FULL). Never combinationally from m_ready.
//  - Latency: beat pushed at edge N visible on m_valid/m_data after edge N (same-cycle as state).
//  - Order preserved; no beat dropped or duplicated under any valid/ready pattern.
//  - Stability: while m_valid & !m_ready, m_valid and m_data hold unchanged.
//  - s_valid while s_ready=0 is ignored (upstream must hold it; not checked here).
//  - Reset (RSTn low, any time incl. mid-transfer): state=EMPTY, m_valid=0, s_ready=0,
//    main/skid=0, stall_cnt=0; in-flight beats discarded. First rising edge after release
//    sets s_ready=1; state stays EMPTY until a push.
//  - X on s_data with s_valid=0 must not propagate into main/skid (load only on push).
// CONFIGURATION
//  - Macro SKID_STALL_CNT_EN: when defined, port stall_cnt exists; 16-bit counter increments
//    every cycle with m_valid=1 & m_ready=0, saturates at 16'hFFFF, never wraps, reset to 0.
//  - Without the macro: port stall_cnt and counter absent; all other behaviour identical.
// STRUCTURE
//  - Shared include basic_define.vh: state encodings SKID_EMPTY=2'd0, SKID_ONE=2'd1,
//    SKID_FULL=2'd2 (2'd3 unreachable, decoded as EMPTY for recovery).
//  - Sub-module basic_reg_en #(DW): rising-edge flop with enable, async active-low reset to 0;
//    instantiated for main and skid payload regs. State/s_ready/counter flops inline.
// TESTING
//  1. Reset: hold RSTn=0 with s_valid=1 -> s_ready=0, m_valid=0, m_data=0; release -> s_ready=1
//     after first edge, m_valid stays 0 until first push.
//  2. Streaming: m_ready=1, push 0x01..0x10 back-to-back -> m_data 0x01..0x10 in order, one per
//     cycle, 1-cycle latency, s_ready constantly 1.
//  3. Backpressure: m_ready=0, push 0xA, 0xB -> s_ready drops after 2nd push, m_data holds 0xA;
//     m_ready=1 -> 0xA then 0xB out, s_ready returns 1 one cycle after first pop.
//  4. Random valid/ready (10k cycles, seeded) -> scoreboard: output sequence equals input,
//     no loss/duplication, m_data stable while m_valid&!m_ready.
//  5. Mid-operation reset in FULL (0xC,0xD held) -> both discarded, outputs to reset values,
//     next push 0xE appears as first output.
//  6. SKID_STALL_CNT_EN defined: m_valid=1, m_ready=0 for 70000 cycles -> stall_cnt=16'hFFFF
//     and holds; reset -> 0. Build without macro compiles and passes tests 1-5.

Source files
------------

// File: rtl/basic_skid_slice_pkg.sv
// Purpose: shared state encodings and helpers for the basic_skid_slice register slice.
// Latency: n/a (types and functions only).
// Backpressure: n/a.
package basic_skid_slice_pkg;

    // Occupancy of the slice. 2'd3 is never produced and is decoded as EMPTY for recovery.
    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_e;

    localparam int          STALL_CNT_W   = 16;
    localparam logic [15:0] STALL_CNT_MAX = 16'hFFFF;

    // Saturating increment: holds at the maximum instead of wrapping to zero.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == STALL_CNT_MAX) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/basic_skid_slice_reg_en.sv
// Purpose: payload register with load enable, cleared to zero by reset.
// Latency: 1 cycle from d/en to q.
// Backpressure: none; loads only when en is high, otherwise holds.
module basic_reg_en #(
    parameter int DW = 32
) (
    input  logic          CLK,
    input  logic          RSTn,
    input  logic          en,
    input  logic [DW-1:0] d,
    output logic [DW-1:0] q
);

    // Load on enable only, so X on d while idle never reaches q.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/basic_skid_slice.sv
// Purpose: two-entry valid/ready skid slice; optional saturating stall counter under SKID_STALL_CNT_EN.
// Latency: 1 cycle, full throughput; s_ready and m_valid both come straight from flops.
// Backpressure: s_ready drops only when both entries are occupied; never combinational from m_ready.
module basic_skid_slice
    import basic_skid_slice_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          CLK,
    input  logic          RSTn,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data
`ifdef SKID_STALL_CNT_EN
    ,
    output logic [15:0]   stall_cnt
`endif
);

    skid_state_e   state_q, state_d;
    logic          s_ready_q, s_ready_d;
    logic          m_valid_q, m_valid_d;
    logic          push, pop;
    logic          main_en, skid_en, main_sel_skid;
    logic [DW-1:0] main_q, skid_q, main_in;

    assign push    = s_valid & s_ready_q;
    assign pop     = m_valid_q & m_ready;
    assign main_in = main_sel_skid ? skid_q : s_data;

    // Next occupancy, payload load enables and the registered handshake outputs.
    always_comb begin
        state_d       = state_q;
        main_en       = 1'b0;
        skid_en       = 1'b0;
        main_sel_skid = 1'b0;
        case (state_q)
            SKID_ONE: begin
                if (push && !pop) begin
                    state_d = SKID_FULL;
                    skid_en = 1'b1;
                end else if (pop && !push) begin
                    state_d = SKID_EMPTY;
                end else if (push && pop) begin
                    main_en = 1'b1;
                end
            end
            SKID_FULL: begin
                // s_ready is low here, so only a pop can move the slice.
                if (pop) begin
                    state_d       = SKID_ONE;
                    main_en       = 1'b1;
                    main_sel_skid = 1'b1;
                end
            end
            default: begin
                // EMPTY, and the unreachable 2'd3 encoding treated the same way.
                if (push) begin
                    state_d = SKID_ONE;
                    main_en = 1'b1;
                end
            end
        endcase
        s_ready_d = (state_d != SKID_FULL);
        m_valid_d = (state_d != SKID_EMPTY);
    end

    // Control flops; reset discards any in-flight beats and deasserts both handshakes.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q   <= SKID_EMPTY;
            s_ready_q <= 1'b0;
            m_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            s_ready_q <= s_ready_d;
            m_valid_q <= m_valid_d;
        end
    end

    basic_reg_en #(.DW(DW)) u_main (
        .CLK  (CLK),
        .RSTn (RSTn),
        .en   (main_en),
        .d    (main_in),
        .q    (main_q)
    );

    basic_reg_en #(.DW(DW)) u_skid (
        .CLK  (CLK),
        .RSTn (RSTn),
        .en   (skid_en),
        .d    (s_data),
        .q    (skid_q)
    );

    assign s_ready = s_ready_q;
    assign m_valid = m_valid_q;
    assign m_data  = main_q;

`ifdef SKID_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Count cycles where a beat is offered downstream but not taken; saturate at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (m_valid_q && !m_ready) begin
            stall_cnt_d = sat_inc16(stall_cnt_q);
        end
    end

    // Stall counter register.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_basic_skid_slice.sv
module tb_basic_skid_slice;

    localparam int DW = 32;

    logic          CLK;
    logic          RSTn;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
`ifdef SKID_STALL_CNT_EN
    logic [15:0]   stall_cnt;
`endif

    int unsigned   errors = 0;
    int unsigned   checks = 0;
    int unsigned   n_pop  = 0;
    logic [DW-1:0] exp_q[$];

    basic_skid_slice #(.DW(DW)) dut (
        .CLK     (CLK),
        .RSTn    (RSTn),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data)
`ifdef SKID_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard for each beat the consumer takes and checks hold stability.
    logic          hold_prev = 1'b0;
    logic [DW-1:0] hold_dat  = '0;
    always @(negedge CLK) begin
        if (!RSTn) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                check("stable_valid", {31'd0, m_valid}, 32'd1);
                check("stable_data", m_data, hold_dat);
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got %h expected none", m_data);
                end else begin
                    check("order", m_data, exp_q.pop_front());
                end
                n_pop++;
            end
            hold_prev = m_valid && !m_ready;
            hold_dat  = m_data;
        end
    end

    // One cycle: drive after the edge, record an accepted beat before the next edge.
    task automatic step(input logic v, input logic [DW-1:0] d, input logic r);
        s_valid = v;
        s_data  = d;
        m_ready = r;
        @(negedge CLK);
        if (s_valid && s_ready && RSTn) exp_q.push_back(s_data);
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RSTn = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge CLK);
        #1;
        RSTn = 1'b1;
    endtask

    initial begin
        int unsigned   pops0;
        logic          v;
        logic [DW-1:0] d;
        RSTn    = 1'b0;
        s_valid = 1'b1;
        s_data  = 32'hDEAD_BEEF;
        m_ready = 1'b0;

        // 1. Reset held with s_valid high.
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst_s_ready", {31'd0, s_ready}, 32'd0);
        check("rst_m_valid", {31'd0, m_valid}, 32'd0);
        check("rst_m_data", m_data, 32'd0);
        @(posedge CLK);
        #1;
        RSTn = 1'b1;
        s_valid = 1'b0;
        @(negedge CLK);
        check("rel_s_ready_before_edge", {31'd0, s_ready}, 32'd0);
        @(posedge CLK);
        #1;
        check("rel_s_ready_after_edge", {31'd0, s_ready}, 32'd1);
        check("rel_m_valid", {31'd0, m_valid}, 32'd0);
        step(1'b0, 'x, 1'b1);
        check("idle_m_valid", {31'd0, m_valid}, 32'd0);
        check("idle_x_blocked", m_data, 32'd0);

        // 2. Back-to-back streaming with the consumer always ready.
        pops0 = n_pop;
        for (int i = 1; i <= 16; i++) begin
            step(1'b1, DW'(i), 1'b1);
            check("stream_s_ready", {31'd0, s_ready}, 32'd1);
            check("stream_latency", m_data, DW'(i));
            check("stream_m_valid", {31'd0, m_valid}, 32'd1);
        end
        step(1'b0, '0, 1'b1);
        check("stream_drained", {31'd0, m_valid}, 32'd0);
        check("stream_count", n_pop - pops0, 32'd16);

        // 3. Backpressure fills both entries, then drains in order.
        step(1'b1, 32'hA, 1'b0);
        check("bp_after_a_ready", {31'd0, s_ready}, 32'd1);
        step(1'b1, 32'hB, 1'b0);
        check("bp_full_ready", {31'd0, s_ready}, 32'd0);
        check("bp_hold_a", m_data, 32'hA);
        step(1'b0, '0, 1'b0);
        check("bp_still_full", {31'd0, s_ready}, 32'd0);
        step(1'b0, '0, 1'b1);
        check("bp_ready_back", {31'd0, s_ready}, 32'd1);
        check("bp_then_b", m_data, 32'hB);
        step(1'b0, '0, 1'b1);
        check("bp_empty", {31'd0, m_valid}, 32'd0);

        // 4. Seeded random valid/ready; upstream holds a refused beat.
        v = $urandom(32'd20240611) & 1;
        v = 1'b0;
        d = '0;
        for (int c = 0; c < 10000; c++) begin
            if (!(v && !s_ready)) begin
                v = ($urandom_range(0, 99) < 60);
                d = $urandom;
            end
            step(v, d, ($urandom_range(0, 99) < 55));
        end
        for (int c = 0; c < 4; c++) step(1'b0, '0, 1'b1);
        check("rand_all_delivered", exp_q.size(), 32'd0);

        // 5. Reset while FULL discards both beats.
        step(1'b1, 32'hC, 1'b0);
        step(1'b1, 32'hD, 1'b0);
        check("mid_full", {31'd0, s_ready}, 32'd0);
        s_valid = 1'b0;
        #1;
        RSTn = 1'b0;
        exp_q.delete();
        #1;
        check("mid_rst_m_valid", {31'd0, m_valid}, 32'd0);
        check("mid_rst_s_ready", {31'd0, s_ready}, 32'd0);
        check("mid_rst_m_data", m_data, 32'd0);
        @(posedge CLK);
        #1;
        RSTn = 1'b1;
        @(posedge CLK);
        #1;
        pops0 = n_pop;
        step(1'b1, 32'hE, 1'b1);
        check("mid_first_out", m_data, 32'hE);
        step(1'b0, '0, 1'b1);
        check("mid_one_out", n_pop - pops0, 32'd1);

`ifdef SKID_STALL_CNT_EN
        // 6. Saturating stall counter.
        do_reset();
        @(posedge CLK);
        #1;
        check("stall_rst", {16'd0, stall_cnt}, 32'd0);
        step(1'b1, 32'h5A, 1'b0);
        for (int c = 0; c < 5; c++) step(1'b0, '0, 1'b0);
        check("stall_five", {16'd0, stall_cnt}, 32'd5);
        repeat (70000) @(posedge CLK);
        #1;
        check("stall_sat", {16'd0, stall_cnt}, 32'h0000_FFFF);
        repeat (3) @(posedge CLK);
        #1;
        check("stall_hold", {16'd0, stall_cnt}, 32'h0000_FFFF);
        do_reset();
        check("stall_cleared", {16'd0, stall_cnt}, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
